// File: rtl/rr_arb_mux.sv
// Round-robin arbiter with one-hot payload select and a single-entry output register.
// Several producers share one downstream valid/ready channel; one beat per cycle at full rate.
module rr_arb_mux #(
  parameter type T       = logic,
  parameter int  REQ_NUM = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req_valid_i,
  output logic [REQ_NUM-1:0] req_ready_o,
  input  T                   req_data_i [REQ_NUM],
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output T                   out_data_o,
  output logic [REQ_NUM-1:0] out_gnt_oh_o
);

  localparam int                   DBL_W   = 2 * REQ_NUM;
  localparam logic [DBL_W-1:0]     DBL_ONE = DBL_W'(1);
  localparam logic [REQ_NUM-1:0]   PTR_RST = REQ_NUM'(1);

  logic [REQ_NUM-1:0] r_ptr;

  logic               w_load_en;
  logic [DBL_W-1:0]   w_req_dbl;
  logic [DBL_W-1:0]   w_mask_dbl;
  logic [DBL_W-1:0]   w_cand_dbl;
  logic [DBL_W-1:0]   w_first_dbl;
  logic [REQ_NUM-1:0] w_gnt;
  logic [REQ_NUM-1:0] w_hs;
  logic               w_any_hs;
  T                   w_sel;

  assign w_load_en = ~out_valid_o | out_ready_i;

  // Upper copy of the request vector covers the wrap-around; the mask keeps only
  // bits at or above the pointer, so the lowest surviving bit is the RR winner.
  assign w_req_dbl   = {req_valid_i, req_valid_i};
  assign w_mask_dbl  = ~({{REQ_NUM{1'b0}}, r_ptr} - DBL_ONE);
  assign w_cand_dbl  = w_req_dbl & w_mask_dbl;
  assign w_first_dbl = w_cand_dbl & (~w_cand_dbl + DBL_ONE);
  assign w_gnt       = w_first_dbl[REQ_NUM-1:0] | w_first_dbl[DBL_W-1:REQ_NUM];

  assign req_ready_o = rst ? '0 : (w_gnt & {REQ_NUM{w_load_en}});
  assign w_hs        = req_ready_o & req_valid_i;
  assign w_any_hs    = |w_hs;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (w_gnt[k]) begin
        w_sel = T'(w_sel | req_data_i[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= PTR_RST;
    end else if (w_any_hs) begin
      r_ptr <= {w_hs[REQ_NUM-2:0], w_hs[REQ_NUM-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_gnt_oh_o <= '0;
    end else if (w_any_hs) begin
      out_valid_o  <= 1'b1;
      out_data_o   <= w_sel;
      out_gnt_oh_o <= w_gnt;
    end else if (out_valid_o && out_ready_i) begin
      // Data is left in place on drain; only valid and source ID clear.
      out_valid_o  <= 1'b0;
      out_gnt_oh_o <= '0;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));
  a_ptr_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot(r_ptr));
  a_gnt_onehot0:   assert property (@(posedge clk) disable iff (rst) $onehot0(out_gnt_oh_o));
  a_valid_gnt:     assert property (@(posedge clk) disable iff (rst) out_valid_o == (|out_gnt_oh_o));
  a_stall_stable:  assert property (@(posedge clk) disable iff (rst)
                     (out_valid_o && !out_ready_i) |=>
                     (out_valid_o && $stable(out_data_o) && $stable(out_gnt_oh_o)));
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed and model-checked bench for rr_arb_mux with 8-bit payload and four requesters.
module tb_rr_arb_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_data [4];
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_gnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.T(logic [7:0]), .REQ_NUM(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_gnt_oh_o (out_gnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] e_rdy;
  logic [3:0] rv;
  int         seq [4];
  int         wait_cnt [4];
  int         m_ptr;
  logic       m_vld;
  logic [7:0] m_data;
  logic [3:0] m_gnt;
  int         e_idx;
  logic       e_load;

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) req_data[k] = 8'h00;
    #12;
    check_eq("rst_ready", req_ready, 4'b0000);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_data",  out_data,  8'h00);
    check_eq("rst_gnt",   out_gnt,   4'b0000);
    check_eq("rst_ptr",   dut.r_ptr, 4'b0001);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    step();

    // rotation with all requesters valid
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) req_data[k] = 8'h10 + 8'(k);
    for (int i = 0; i < 5; i++) begin
      #1;
      e_rdy = 4'b0001 << (i % 4);
      check_eq("rot_ready", req_ready, e_rdy);
      step();
      check_eq("rot_valid", out_valid, 1'b1);
      check_eq("rot_data",  out_data,  32'h10 + 32'(i % 4));
      check_eq("rot_gnt",   out_gnt,   e_rdy);
    end
    check_eq("rot_ptr", dut.r_ptr, 4'b0010);
    req_valid = 4'b0000;
    step();
    check_eq("drain_valid", out_valid, 1'b0);
    check_eq("drain_gnt",   out_gnt,   4'b0000);
    check_eq("drain_hold",  out_data,  8'h10);

    // backpressure
    req_valid   = 4'b0110;
    req_data[1] = 8'h41;
    req_data[2] = 8'h42;
    out_ready   = 1'b0;
    #1;
    check_eq("bp_ready0", req_ready, 4'b0010);
    step();
    req_valid = 4'b0100;
    check_eq("bp_data0", out_data,  8'h41);
    check_eq("bp_gnt0",  out_gnt,   4'b0010);
    check_eq("bp_ptr0",  dut.r_ptr, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_ready", req_ready, 4'b0000);
      step();
      check_eq("bp_valid", out_valid, 1'b1);
      check_eq("bp_data",  out_data,  8'h41);
      check_eq("bp_gnt",   out_gnt,   4'b0010);
      check_eq("bp_ptr",   dut.r_ptr, 4'b0100);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_rel_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    check_eq("bp_rel_valid", out_valid, 1'b1);
    check_eq("bp_rel_data",  out_data,  8'h42);
    check_eq("bp_rel_gnt",   out_gnt,   4'b0100);
    check_eq("bp_rel_ptr",   dut.r_ptr, 4'b1000);
    step();

    // ptr at 3: grant to 3 over 0
    req_valid   = 4'b1001;
    req_data[0] = 8'h30;
    req_data[3] = 8'h33;
    #1;
    check_eq("w3_ready", req_ready, 4'b1000);
    step();
    req_valid = 4'b0000;
    check_eq("w3_data", out_data,  8'h33);
    check_eq("w3_gnt",  out_gnt,   4'b1000);
    check_eq("w3_ptr",  dut.r_ptr, 4'b0001);

    // single requester 2
    req_valid   = 4'b0100;
    req_data[2] = 8'hA5;
    #1;
    check_eq("s2_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    check_eq("s2_valid", out_valid, 1'b1);
    check_eq("s2_data",  out_data,  8'hA5);
    check_eq("s2_gnt",   out_gnt,   4'b0100);
    check_eq("s2_ptr",   dut.r_ptr, 4'b1000);

    // wrap and skip: ptr 3, requests 0 and 1
    req_valid   = 4'b0011;
    req_data[0] = 8'h30;
    req_data[1] = 8'h31;
    #1;
    check_eq("wr_ready0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    check_eq("wr_data0", out_data,  8'h30);
    check_eq("wr_ptr0",  dut.r_ptr, 4'b0010);
    #1;
    check_eq("wr_ready1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    check_eq("wr_data1", out_data,  8'h31);
    check_eq("wr_gnt1",  out_gnt,   4'b0010);
    check_eq("wr_ptr1",  dut.r_ptr, 4'b0100);

    // async reset while holding a beat
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_valid", out_valid, 1'b0);
    check_eq("mrst_data",  out_data,  8'h00);
    check_eq("mrst_gnt",   out_gnt,   4'b0000);
    check_eq("mrst_ptr",   dut.r_ptr, 4'b0001);
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    #1;
    check_eq("idle_ready", req_ready, 4'b0000);
    check_eq("idle_valid", out_valid, 1'b0);
    check_eq("idle_data",  out_data,  8'h00);

    // random valid/ready against a reference model
    rv     = 4'b0000;
    m_ptr  = 0;
    m_vld  = 1'b0;
    m_data = 8'h00;
    m_gnt  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      seq[k]      = 0;
      wait_cnt[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!rv[k] && ($urandom_range(1, 0) != 0)) begin
          rv[k]       = 1'b1;
          seq[k]      = seq[k] + 1;
          wait_cnt[k] = 0;
          req_data[k] = 8'(k * 64 + (seq[k] % 64));
        end
      end
      req_valid = rv;
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      e_idx = -1;
      for (int i = 0; i < 4; i++) begin
        if (e_idx < 0 && rv[(m_ptr + i) % 4]) e_idx = (m_ptr + i) % 4;
      end
      e_load = !m_vld || out_ready;
      e_rdy  = (e_load && e_idx >= 0) ? (4'b0001 << e_idx) : 4'b0000;
      check_eq("rnd_ready", req_ready, e_rdy);
      step();
      if (e_rdy != 4'b0000) begin
        check_eq("rnd_fair", (wait_cnt[e_idx] <= 3), 1'b1);
        for (int k = 0; k < 4; k++) if (rv[k] && k != e_idx) wait_cnt[k]++;
        wait_cnt[e_idx] = 0;
        m_vld     = 1'b1;
        m_data    = req_data[e_idx];
        m_gnt     = e_rdy;
        m_ptr     = (e_idx + 1) % 4;
        rv[e_idx] = 1'b0;
      end else if (m_vld && out_ready) begin
        m_vld = 1'b0;
        m_gnt = 4'b0000;
      end
      check_eq("rnd_valid", out_valid, m_vld);
      check_eq("rnd_data",  out_data,  m_data);
      check_eq("rnd_gnt",   out_gnt,   m_gnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
